trunc_issue_stage: RTL and testbench

- Registered issue/retire stage wrapped around the team's combinational 32-bit truncate unit (Truncate_32bit).
- Accepts truncate commands from the ALU operand path over a valid/ready handshake and buffers them in a 2-entry command queue.
- Presents the head command to Truncate_32bit and delivers the registered result, with zero flag and tag, downstream over valid/ready.
- Keeps a retired-operation counter for debug.

---
 rtl/trunc_issue_stage.sv | 151 +++++++++++++++
 tb/tb_trunc_issue_stage.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trunc_issue_stage.sv
// -----------------------------------------------------------------------------
// trunc_issue_stage
//
// Registered issue/retire stage around the combinational 32-bit truncate unit.
// Commands {a, dir, bite, tag} enter over a valid/ready handshake into a
// 2-entry circular queue. The queue head feeds Truncate_32bit, and its result
// is loaded into an output register together with a zero flag and the tag.
// The output register is presented downstream over valid/ready. A wrapping
// counter tracks how many results have been accepted downstream.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     command present
//   in_ready     stage can accept a command (registered-state based)
//   in_a         32-bit operand
//   in_dir       0 = keep upper (bite+1) bits, 1 = keep lower (bite+1) bits
//   in_bite      truncation index
//   in_tag       opaque command tag
//   out_valid    result present
//   out_ready    consumer accepts the result this cycle
//   out_s        truncated result
//   out_zero     out_s == 0
//   out_tag      tag of the result
//   retired_cnt  number of results accepted downstream (wraps)
//   busy         queue non-empty or result pending
// -----------------------------------------------------------------------------

// Combinational truncate unit: keeps (bite+1) bits at the low end (dir=1) or
// the high end (dir=0) of a, clearing the rest.
module Truncate_32bit (
  input  logic [31:0] a,
  input  logic        dir,
  input  logic [4:0]  bite,
  output logic [31:0] s
);

  always_comb begin
    s = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (dir) begin
        if (i <= 32'(bite)) s[i] = a[i];
      end else begin
        if (i >= 32'd31 - 32'(bite)) s[i] = a[i];
      end
    end
  end

endmodule

module trunc_issue_stage #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic             in_dir,
  input  logic [4:0]       in_bite,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_s,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             busy
);

  // Command queue storage (data only, no reset needed)
  logic [31:0]      q_a    [2];
  logic             q_dir  [2];
  logic [4:0]       q_bite [2];
  logic [TAG_W-1:0] q_tag  [2];

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  logic        push;
  logic        pop;
  logic        out_free;
  logic [31:0] head_s;

  // in_ready looks only at the registered count, so a full queue cannot take
  // a new command in the same cycle it pops; the upstream retries next cycle.
  assign in_ready = (count < 2'd2);
  assign push     = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;
  assign pop      = (count != 2'd0) && out_free;
  assign busy     = (count != 2'd0) || out_valid;

  Truncate_32bit u_trunc (
    .a    (q_a[rd_ptr]),
    .dir  (q_dir[rd_ptr]),
    .bite (q_bite[rd_ptr]),
    .s    (head_s)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      q_a[wr_ptr]    <= in_a;
      q_dir[wr_ptr]  <= in_dir;
      q_bite[wr_ptr] <= in_bite;
      q_tag[wr_ptr]  <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_s     <= '0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_s     <= head_s;
      out_zero  <= (head_s == 32'd0);
      out_tag   <= q_tag[rd_ptr];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (out_valid && out_ready) begin
      retired_cnt <= retired_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_trunc_issue_stage.sv
module tb_trunc_issue_stage;

  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic             in_dir;
  logic [4:0]       in_bite;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_s;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] retired_cnt;
  logic             busy;

  trunc_issue_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_dir(in_dir), .in_bite(in_bite), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_zero(out_zero), .out_tag(out_tag),
    .retired_cnt(retired_cnt), .busy(busy)
  );

  // Small-counter instance used only for the wrap check
  logic             w_in_valid;
  logic             w_in_ready;
  logic             w_out_valid;
  logic [31:0]      w_out_s;
  logic             w_out_zero;
  logic [TAG_W-1:0] w_out_tag;
  logic [3:0]       w_cnt;
  logic             w_busy;

  trunc_issue_stage #(.TAG_W(TAG_W), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(32'hA5A5_5A5A), .in_dir(1'b1), .in_bite(5'd15), .in_tag(4'd6),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .out_s(w_out_s), .out_zero(w_out_zero), .out_tag(w_out_tag),
    .retired_cnt(w_cnt), .busy(w_busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a FIFO of expected results in delivery order.
  typedef struct {
    logic [31:0]      s;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             exp_item;
  logic             have_exp;
  logic [CNT_W-1:0] exp_cnt;
  logic             in_hs;
  logic             out_hs;
  logic [31:0]      o_s;
  logic             o_zero;
  logic [TAG_W-1:0] o_tag;

  function automatic logic [31:0] ref_trunc(input logic [31:0] a, input logic dir,
                                            input logic [4:0] b);
    logic [63:0] keep;
    if (dir) keep = (64'd1 << (int'(b) + 1)) - 64'd1;
    else     keep = ~((64'd1 << (31 - int'(b))) - 64'd1);
    return a & keep[31:0];
  endfunction

  // Advance one clock: sample handshakes at the falling edge, update the model,
  // then return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    in_hs    = in_valid && in_ready && !rst;
    out_hs   = out_valid && out_ready && !rst;
    o_s      = out_s;
    o_zero   = out_zero;
    o_tag    = out_tag;
    have_exp = 1'b0;
    if (out_hs) begin
      exp_cnt++;
      if (exp_q.size() > 0) begin
        exp_item = exp_q.pop_front();
        have_exp = 1'b1;
      end
    end
    if (in_hs) exp_q.push_back('{ref_trunc(in_a, in_dir, in_bite), in_tag});
    if (rst) begin
      exp_q.delete();
      exp_cnt = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_random(input logic [TAG_W-1:0] tag);
    in_a    = $urandom;
    in_dir  = 1'($urandom_range(0, 1));
    in_bite = 5'($urandom_range(0, 31));
    in_tag  = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid_busy: out_valid=%b busy=%b expected 0 0", out_valid, busy);
    end
    n_cmp++;
    if (out_s !== 32'h0 || out_zero !== 1'b0 || out_tag !== '0) begin
      n_fail++;
      $display("FAIL reset_data: out_s=%h zero=%b tag=%0d expected 0 0 0", out_s, out_zero, out_tag);
    end
    n_cmp++;
    if (retired_cnt !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cnt_ready: cnt=%0d in_ready=%b expected 0 1", retired_cnt, in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_a = 32'hDEAD_BEEF; in_dir = 1'b1; in_bite = 5'd7; in_tag = 4'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (in_hs !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept: accepted=%b expected 1", in_hs);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency_early: out_valid=%b expected 0 one cycle after accept", out_valid);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_s !== 32'h0000_00EF || out_tag !== 4'd3 || out_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: valid=%b s=%h tag=%0d zero=%b expected 1 000000ef 3 0",
               out_valid, out_s, out_tag, out_zero);
    end
    tick();
    n_cmp++;
    if (out_hs !== 1'b1 || retired_cnt !== 16'd1 || retired_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL single_retire: handshake=%b cnt=%0d expected 1 1", out_hs, retired_cnt);
    end
  endtask

  task automatic test_arith();
    logic [31:0] va [6] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678,
                            32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic        vd [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0]  vb [6] = '{5'd7, 5'd31, 5'd31, 5'd30, 5'd0, 5'd0};
    logic [31:0] ve [6] = '{32'hDE00_0000, 32'h1234_5678, 32'h1234_5678,
                            32'h0000_0000, 32'h0000_0001, 32'h8000_0000};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bit seen;
      seen = 1'b0;
      in_a = va[k]; in_dir = vd[k]; in_bite = vb[k]; in_tag = 4'(k + 8);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 5 && !seen; c++) begin
        tick();
        if (out_hs) begin
          seen = 1'b1;
          n_cmp++;
          if (o_s !== ve[k] || o_zero !== (ve[k] == 32'h0) || o_tag !== 4'(k + 8) ||
              !have_exp || o_s !== exp_item.s) begin
            n_fail++;
            $display("FAIL arith_%0d: s=%h zero=%b tag=%0d expected s=%h zero=%b tag=%0d",
                     k, o_s, o_zero, o_tag, ve[k], (ve[k] == 32'h0), k + 8);
          end
        end
      end
      if (!seen) begin
        n_cmp++;
        n_fail++;
        $display("FAIL arith_%0d_timeout: no result within 5 cycles, expected one", k);
      end
    end
  endtask

  task automatic test_backpressure();
    int          sent;
    int          got;
    logic [31:0] held;
    sent = 0;
    got  = 0;
    out_ready = 1'b0;
    load_random(4'd1);
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (in_hs) begin
        sent++;
        load_random(4'(sent + 1));
      end
    end
    n_cmp++;
    if (sent != 3 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 4'd1) begin
      n_fail++;
      $display("FAIL bp_fill: accepted=%0d in_ready=%b out_valid=%b tag=%0d expected 3 0 1 1",
               sent, in_ready, out_valid, out_tag);
    end
    held = out_s;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (out_s !== held || in_ready !== 1'b0 || in_hs !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: s=%h in_ready=%b accepted=%b expected s=%h 0 0",
                 out_s, in_ready, in_hs, held);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12 && got < 4; c++) begin
      tick();
      if (in_hs) begin
        sent++;
        if (sent == 4) in_valid = 1'b0;
      end
      if (out_hs) begin
        got++;
        n_cmp++;
        if (!have_exp || o_s !== exp_item.s || o_tag !== exp_item.tag ||
            o_tag !== 4'(got) || o_zero !== (exp_item.s == 32'h0)) begin
          n_fail++;
          $display("FAIL bp_drain: s=%h tag=%0d zero=%b expected s=%h tag=%0d",
                   o_s, o_tag, o_zero, exp_item.s, got);
        end
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL bp_count: delivered=%0d expected 4", got);
    end
  endtask

  task automatic test_stream();
    int sent;
    int got;
    int first_c;
    int last_c;
    int bad;
    sent = 0; got = 0; first_c = -1; last_c = -1; bad = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    load_random(4'd0);
    in_valid = 1'b1;
    for (int c = 0; c < 400 && got < 100; c++) begin
      tick();
      if (in_hs) begin
        sent++;
        if (sent < 100) load_random(4'(sent));
        else in_valid = 1'b0;
      end
      if (out_hs) begin
        got++;
        if (first_c < 0) first_c = c;
        last_c = c;
        if (!have_exp || o_s !== exp_item.s || o_tag !== exp_item.tag ||
            o_zero !== (exp_item.s == 32'h0)) begin
          bad++;
          $display("FAIL stream_result_%0d: s=%h tag=%0d zero=%b expected s=%h tag=%0d",
                   got, o_s, o_tag, o_zero, exp_item.s, exp_item.tag);
        end
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (bad != 0) n_fail++;
    n_cmp++;
    if (got != 100 || last_c - first_c != 99) begin
      n_fail++;
      $display("FAIL stream_rate: results=%0d span=%0d expected 100 99", got, last_c - first_c);
    end
    n_cmp++;
    if (retired_cnt !== 16'd100 || retired_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL stream_count: cnt=%0d expected 100", retired_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int sent;
    int stale;
    sent  = 0;
    stale = 0;
    out_ready = 1'b0;
    load_random(4'd9);
    in_valid = 1'b1;
    for (int c = 0; c < 6 && sent < 3; c++) begin
      tick();
      if (in_hs) begin
        sent++;
        load_random(4'(9 + sent));
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (sent != 3 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_setup: accepted=%0d out_valid=%b in_ready=%b expected 3 1 0",
               sent, out_valid, in_ready);
    end
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || retired_cnt !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_state: out_valid=%b busy=%b cnt=%0d in_ready=%b expected 0 0 0 1",
               out_valid, busy, retired_cnt, in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid || busy) stale++;
    end
    n_cmp++;
    if (stale != 0 || retired_cnt !== '0) begin
      n_fail++;
      $display("FAIL rmid_stale: stale_cycles=%0d cnt=%0d expected 0 0", stale, retired_cnt);
    end
  endtask

  task automatic test_wrap();
    int  n_acc;
    int  n_out;
    logic acc;
    logic ohs;
    n_acc = 0;
    n_out = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    w_in_valid = 1'b1;
    for (int c = 0; c < 60 && (n_out < 17 || w_busy); c++) begin
      @(negedge clk);
      acc = w_in_valid && w_in_ready;
      ohs = w_out_valid;
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        if (n_acc == 17) w_in_valid = 1'b0;
      end
      if (ohs) n_out++;
    end
    w_in_valid = 1'b0;
    n_cmp++;
    if (n_out != 17 || w_cnt !== 4'(n_out % 16) || w_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap_count: retired=%0d cnt=%0d expected 17 1", n_out, w_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_dir = 1'b0; in_bite = '0; in_tag = '0;
    out_ready = 1'b0; w_in_valid = 1'b0; exp_cnt = '0;
    test_reset();
    test_single();
    test_arith();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
